wr_order_queue: RTL and testbench

Parametrised write-data ordering queue for the AXI interconnect write path. Records, in AW-grant order, the master ID, split-burst flag and burst length of every granted write address, presents the oldest entry to the W-channel mux, counts its data beats and retires it on the final beat. Supersedes the fixed two-entry ordering queue: depth is configurable, simultaneous push/pop is supported, beat tracking is built in, and WLAST/overflow errors are flagged.

---
 rtl/wr_order_queue.sv | 118 +++++++++++
 tb/tb_wr_order_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wr_order_queue.sv
// Write-data ordering queue. Entries are recorded in AW-grant order and the
// oldest one is presented to the W-channel mux. Its data beats are counted,
// and the entry retires on the beat that the burst length says is final.
module wr_order_queue #(
  parameter int Masters_Num = 2,
  parameter int ID_Size     = $clog2(Masters_Num),
  parameter int Depth       = 4,
  parameter int Len_Width   = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     Push,
  input  logic [ID_Size-1:0]       Push_Master_ID,
  input  logic                     Push_Split,
  input  logic [Len_Width-1:0]     Push_Len,
  input  logic                     W_Beat,
  input  logic                     W_Last,
  output logic                     Queue_Full,
  output logic                     Queue_Empty,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Master_Valid,
  output logic [ID_Size-1:0]       Head_Master_ID,
  output logic                     Head_Is_Split,
  output logic                     Head_Start_Pulse,
  output logic [Len_Width-1:0]     Beat_Count,
  output logic                     Expect_Last,
  output logic                     Last_Error,
  output logic                     Overflow_Error
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  // Entry storage, one slot per queue position.
  logic [ID_Size-1:0]   id_q    [Depth];
  logic                 split_q [Depth];
  logic [Len_Width-1:0] len_q   [Depth];

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [Len_Width-1:0] beat_q, beat_d;
  logic                 valid_q, popped_q;
  logic                 last_err_q, last_err_d;
  logic                 ovf_q, ovf_d;

  logic [AW-1:0]        wr_idx, rd_idx;
  logic                 full, empty;
  logic                 push_ok, pop;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  assign Queue_Full       = full;
  assign Queue_Empty      = empty;
  assign Count            = wr_ptr_q - rd_ptr_q;
  assign Master_Valid     = !empty;
  assign Head_Master_ID   = id_q[rd_idx];
  assign Head_Is_Split    = split_q[rd_idx];
  assign Beat_Count       = beat_q;
  assign Expect_Last      = Master_Valid && (beat_q == len_q[rd_idx]);
  // A new head appears either after the queue was empty or right after a retire.
  assign Head_Start_Pulse = Master_Valid && (!valid_q || popped_q);
  assign Last_Error       = last_err_q;
  assign Overflow_Error   = ovf_q;

  // Next-state: push/pop decisions, beat counter and error detection.
  always_comb begin
    push_ok    = Push && !full;
    pop        = W_Beat && Expect_Last;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    last_err_d = W_Beat && Master_Valid && (W_Last != Expect_Last);
    ovf_d      = Push && full;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      beat_d   = '0;
    end else if (W_Beat && Master_Valid) begin
      beat_d   = beat_q + Len_Width'(1);
    end
  end

  // State registers and entry write on an accepted push.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      valid_q    <= 1'b0;
      popped_q   <= 1'b0;
      last_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        id_q[i]    <= '0;
        split_q[i] <= 1'b0;
        len_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      valid_q    <= Master_Valid;
      popped_q   <= pop;
      last_err_q <= last_err_d;
      ovf_q      <= ovf_d;
      if (push_ok) begin
        id_q[wr_idx]    <= Push_Master_ID;
        split_q[wr_idx] <= Push_Split;
        len_q[wr_idx]   <= Push_Len;
      end
    end
  end

endmodule

// File: tb/tb_wr_order_queue.sv
// Directed bench for wr_order_queue (4 masters, Depth 4, 8-bit lengths).
module tb_wr_order_queue;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       Push, Push_Split, W_Beat, W_Last;
  logic [1:0] Push_Master_ID;
  logic [7:0] Push_Len;
  logic       Queue_Full, Queue_Empty, Master_Valid, Head_Is_Split;
  logic       Head_Start_Pulse, Expect_Last, Last_Error, Overflow_Error;
  logic [2:0] Count;
  logic [1:0] Head_Master_ID;
  logic [7:0] Beat_Count;

  int n_chk  = 0;
  int n_pass = 0;
  int mq_id[$];
  int mq_len[$];

  wr_order_queue #(.Masters_Num(4), .Depth(4), .Len_Width(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .Push(Push), .Push_Master_ID(Push_Master_ID),
    .Push_Split(Push_Split), .Push_Len(Push_Len), .W_Beat(W_Beat), .W_Last(W_Last),
    .Queue_Full(Queue_Full), .Queue_Empty(Queue_Empty), .Count(Count),
    .Master_Valid(Master_Valid), .Head_Master_ID(Head_Master_ID),
    .Head_Is_Split(Head_Is_Split), .Head_Start_Pulse(Head_Start_Pulse),
    .Beat_Count(Beat_Count), .Expect_Last(Expect_Last), .Last_Error(Last_Error),
    .Overflow_Error(Overflow_Error)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // One clock with the given inputs held across the edge, then back to idle.
  task automatic cyc(input logic p, input logic [1:0] id, input logic sp,
                     input logic [7:0] ln, input logic b, input logic l);
    Push = p; Push_Master_ID = id; Push_Split = sp; Push_Len = ln;
    W_Beat = b; W_Last = l;
    step();
    Push = 0; Push_Master_ID = 0; Push_Split = 0; Push_Len = 0;
    W_Beat = 0; W_Last = 0;
  endtask

  function automatic logic [31:0] others();
    return 32'({Queue_Full, Count, Master_Valid, Head_Master_ID, Head_Is_Split,
                Head_Start_Pulse, Beat_Count, Expect_Last, Last_Error, Overflow_Error});
  endfunction

  // Retire the model head beat by beat, checking the count as it goes.
  task automatic drain_head(input string tag);
    int len;
    len = mq_len[0];
    chk({tag, " head_id"}, 32'(Head_Master_ID), 32'(mq_id[0]));
    for (int b = 0; b <= len; b++) begin
      chk({tag, " beat_cnt"}, 32'(Beat_Count), 32'(b));
      chk({tag, " exp_last"}, 32'(Expect_Last), 32'(b == len));
      cyc(0, 0, 0, 0, 1, b == len);
      chk({tag, " last_err"}, 32'(Last_Error), 0);
    end
    void'(mq_id.pop_front());
    void'(mq_len.pop_front());
    chk({tag, " count"}, 32'(Count), 32'(mq_id.size()));
    chk({tag, " start"}, 32'(Head_Start_Pulse), 32'(mq_id.size() > 0));
  endtask

  initial begin
    ARESET = 1; Push = 0; Push_Master_ID = 0; Push_Split = 0; Push_Len = 0;
    W_Beat = 0; W_Last = 0;
    step(); step();
    ARESET = 0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      chk("idle empty", 32'(Queue_Empty), 1);
      chk("idle others", others(), 0);
      step();
    end

    // Fill with IDs 1,0,1,0 (single-beat bursts).
    cyc(1, 1, 0, 0, 0, 0);
    chk("fill1 valid", 32'(Master_Valid), 1);
    chk("fill1 start", 32'(Head_Start_Pulse), 1);
    chk("fill1 explast", 32'(Expect_Last), 1);
    chk("fill1 head", 32'(Head_Master_ID), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("fill2 start", 32'(Head_Start_Pulse), 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("full flag", 32'(Queue_Full), 1);
    chk("full count", 32'(Count), 4);
    chk("full ovf", 32'(Overflow_Error), 0);
    cyc(1, 3, 0, 0, 0, 0);
    chk("ovf pulse", 32'(Overflow_Error), 1);
    chk("ovf count", 32'(Count), 4);
    step();
    chk("ovf clear", 32'(Overflow_Error), 0);
    chk("ovf head", 32'(Head_Master_ID), 1);

    // Push while full with a same-cycle final beat: push dropped, pop happens.
    cyc(1, 3, 0, 0, 1, 1);
    chk("fullpp ovf", 32'(Overflow_Error), 1);
    chk("fullpp count", 32'(Count), 3);
    chk("fullpp head", 32'(Head_Master_ID), 0);
    chk("fullpp start", 32'(Head_Start_Pulse), 1);
    // Push + pop with 3 entries: count holds.
    cyc(1, 2, 0, 0, 1, 1);
    chk("pp count", 32'(Count), 3);
    chk("pp ovf", 32'(Overflow_Error), 0);
    chk("pp head", 32'(Head_Master_ID), 1);
    chk("pp start", 32'(Head_Start_Pulse), 1);
    step();
    chk("pp start off", 32'(Head_Start_Pulse), 0);
    mq_id = '{1, 0, 2}; mq_len = '{0, 0, 0};
    while (mq_id.size() > 0) drain_head("drain");
    chk("drain empty", 32'(Queue_Empty), 1);

    // Four-beat split burst with WLAST on the last beat.
    cyc(1, 1, 1, 3, 0, 0);
    chk("b4 split", 32'(Head_Is_Split), 1);
    mq_id = '{1}; mq_len = '{3};
    drain_head("b4");
    chk("b4 empty", 32'(Queue_Empty), 1);

    // Early WLAST on a three-beat burst.
    cyc(1, 1, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("early err0", 32'(Last_Error), 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("early err", 32'(Last_Error), 1);
    chk("early valid", 32'(Master_Valid), 1);
    chk("early beat", 32'(Beat_Count), 2);
    cyc(0, 0, 0, 0, 1, 1);
    chk("early err clr", 32'(Last_Error), 0);
    chk("early retire", 32'(Queue_Empty), 1);

    // Beat while empty is ignored.
    cyc(0, 0, 0, 0, 1, 0);
    chk("empty beat", others(), 0);

    // Stream 20 entries through, wrapping the pointers several times.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 2'(i % 4), 1'(i % 2), 8'(i % 3), 0, 0);
      mq_id.push_back(i % 4); mq_len.push_back(i % 3);
      chk("wrap count", 32'(Count), 32'(mq_id.size()));
      if (mq_id.size() >= 2) drain_head("wrap");
    end
    while (mq_id.size() > 0) drain_head("wrap tail");

    // Reset in the middle of a burst.
    cyc(1, 1, 0, 3, 0, 0);
    cyc(1, 2, 0, 3, 0, 0);
    cyc(1, 3, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("mid beat", 32'(Beat_Count), 2);
    chk("mid count", 32'(Count), 3);
    ARESET = 1;
    step();
    ARESET = 0;
    chk("rst count", 32'(Count), 0);
    chk("rst beat", 32'(Beat_Count), 0);
    chk("rst empty", 32'(Queue_Empty), 1);
    chk("rst others", others(), 0);
    step();
    chk("rst idle", others(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
